frs_arbiter: RTL
================

# frs_arbiter

Two-requester arbiter and sequencer for the TPM register space (FRS) port. It lets the SPI-side controller (host) and an internal TPM command engine (core) share the single FRS access port. It serialises their byte accesses, issues each as a one-cycle request to the register space and returns read data with an acknowledge pulse. Round-robin ownership plus a lock lets either side hold the port across a multi-byte burst. A watchdog frees a lock that has gone idle.

## Interface
- RD_LATENCY, 1: cycles from the `reg_req` cycle to the cycle `reg_rdByte` is valid (1..15).
- LOCK_MAX, 255: consecutive idle cycles tolerated under a held lock before forced release (1..255).
- clock  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- h_req / c_req  in  1  host / core access request, level; held until the matching ack.
- h_lock / c_lock  in  1  keep ownership after the current access.
- h_dir / c_dir  in  1  1 = read, 0 = write (FRS wren_n sense).
- h_size / c_size  in  6  command size, passed through.
- h_addr / c_addr  in  16  FRS byte address.
- h_baseAddr / c_baseAddr  in  16  FRS base address, passed through.
- h_wrByte / c_wrByte  in  8  write data.
- h_ack / c_ack  out  1  one-cycle completion pulse to the requester.
- h_rdByte / c_rdByte  out  8  read data, valid with ack, held until that side's next ack.
- reg_req  out  1  one-cycle access strobe to the register space.
- reg_dir, reg_size, reg_addr, reg_baseAddr, reg_wrByte  out  1/6/16/16/8  registered copy of the winner's fields.
- reg_rdByte  in  8  register-space read data.
- owner  out  1  0 = host, 1 = core; the last or current grantee.
- busy  out  1  high from grant until ack inclusive.
- lock_abort  out  1  one-cycle pulse when the watchdog forces a lock release.

## Operation
- **State machine:** IDLE -> ISSUE -> WAIT -> ACK -> IDLE.
- **IDLE:**
  - Samples `h_req` and `c_req` and picks a winner.
  - Latches the winner's dir, size, addr, baseAddr and wrByte into the `reg_*` registers.
  - Sets `owner` and `busy`, then moves to ISSUE.
- **ISSUE:** `reg_req`=1 for exactly one cycle; WAIT follows.
- **WAIT:** counts RD_LATENCY-1 cycles. With RD_LATENCY=1, WAIT lasts 0 cycles and ISSUE goes straight to ACK.
- **ACK:**
  - Pulses the winner's ack.
  - On a read (dir=1), captures `reg_rdByte` into the winner's rdByte.
  - On a write, leaves the winner's rdByte unchanged.
  - Clears `busy` next cycle.
- **Arbitration with no lock held:**
  - A single request wins.
  - When both request, the side not equal to `owner` wins (round-robin).
- **Lock:**
  - The lock is held if the owner's lock input is 1 in the ACK cycle.
  - While held, IDLE considers only the owner's req; the other side waits.
  - The lock is released in any IDLE cycle where the owner's lock input is 0; normal arbitration applies in that same cycle.
- **Watchdog:**
  - Counts IDLE cycles with the lock held and the owner's req at 0.
  - The count is 8 bits and resets whenever the owner's req=1 or the lock is released.
  - When the count reaches LOCK_MAX: release the lock, pulse `lock_abort`, and arbitrate normally the next cycle.
- **Once issued, an access always completes.** Dropping req after the grant does not cancel it; the ack still pulses and the requester ignores it.
- **Fields** are captured only in IDLE. Changes to requester inputs after the grant have no effect on the access in flight.

## Timing
- Request first seen in IDLE at edge N:
  - `reg_req` high in cycle N+1.
  - ack high in cycle N+1+RD_LATENCY.
  - rdByte updated in the same cycle as ack.
- **Single-requester throughput:** one access per RD_LATENCY+2 cycles. The requester must present its next access, or drop req, by the cycle after ack.
- **Reset values** (asynchronous, all outputs):
  - state=IDLE, `reg_req`=0, `reg_dir`=1.
  - `reg_size`, `reg_addr`, `reg_baseAddr`, `reg_wrByte`=0.
  - acks=0, rdBytes=0x00.
  - `owner`=1 (core), so the host wins the first tie.
  - `busy`=0, `lock_abort`=0, lock cleared, watchdog count=0.
- **Reset mid-access:** the access is abandoned, no ack is issued and nothing further reaches the register space.
- **No combinational paths** from inputs to outputs.

## Test plan
- **Host read, RD_LATENCY=1:**
  - Stimulus: `h_req`=1, dir=1, addr=0x0F00 at edge N; register space returns 0x5A.
  - Required: `reg_req` high in cycle N+1 only, `reg_addr`=0x0F00; `h_ack` in N+2 with `h_rdByte`=0x5A; `c_ack` stays 0.
- **Simultaneous requests from reset:**
  - Stimulus: both sides hold req=1 continuously.
  - Required: grants alternate host, core, host, core; `owner` toggles 0,1,0,1; one access every 3 cycles.
- **Core lock:**
  - Stimulus: core does 4 writes with `c_lock`=1 while `h_req`=1 throughout.
  - Required: no host grant until `c_lock`=0 in an IDLE cycle; the host is granted in that cycle.
- **Watchdog, LOCK_MAX=4:**
  - Stimulus: the host holds `h_lock`=1 and drops `h_req` after its ack; `c_req`=1.
  - Required: `lock_abort` pulses after 4 idle cycles; the core is granted the following cycle.
- **RD_LATENCY=3 and a write:**
  - Stimulus: a read, then a write of 0xC3.
  - Required: ack arrives 4 cycles after the grant; `reg_dir`=0 and `reg_wrByte`=0xC3 for the write; `h_rdByte` keeps the earlier read value.
- **Reset during WAIT, then request dropped mid-access:**
  - Stimulus: assert `reset_n`=0 during WAIT; after reset, start an access and drop req after the grant.
  - Required: after the reset, all outputs hold their reset values and no ack pulses. The access started after reset still pulses ack.

Source files
------------

// File: rtl/frs_arbiter.sv
// frs_arbiter: shares the single FRS register-space port between the SPI host and the TPM core.
// Round-robin arbitration with an ownership lock, a lock watchdog and fixed-latency read return.
module frs_arbiter #(
  parameter int RD_LATENCY = 1,
  parameter int LOCK_MAX   = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        h_req,
  input  logic        c_req,
  input  logic        h_lock,
  input  logic        c_lock,
  input  logic        h_dir,
  input  logic        c_dir,
  input  logic [5:0]  h_size,
  input  logic [5:0]  c_size,
  input  logic [15:0] h_addr,
  input  logic [15:0] c_addr,
  input  logic [15:0] h_baseAddr,
  input  logic [15:0] c_baseAddr,
  input  logic [7:0]  h_wrByte,
  input  logic [7:0]  c_wrByte,
  output logic        h_ack,
  output logic        c_ack,
  output logic [7:0]  h_rdByte,
  output logic [7:0]  c_rdByte,
  output logic        reg_req,
  output logic        reg_dir,
  output logic [5:0]  reg_size,
  output logic [15:0] reg_addr,
  output logic [15:0] reg_baseAddr,
  output logic [7:0]  reg_wrByte,
  input  logic [7:0]  reg_rdByte,
  output logic        owner,
  output logic        busy,
  output logic        lock_abort
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

  // Last WAIT count before ACK; unused when RD_LATENCY is 1 (WAIT is skipped).
  localparam logic [3:0] WAIT_LAST = 4'((RD_LATENCY > 1) ? RD_LATENCY - 2 : 0);
  localparam logic [7:0] WD_LAST   = 8'(LOCK_MAX - 1);

  state_t     state_q, state_d;
  logic [3:0] wait_cnt_q;
  logic [7:0] wd_cnt_q;
  logic       lock_q;

  logic own_req, own_lock, locked, grant, grant_side, wd_fire;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next state plus the IDLE-cycle arbitration decision.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    own_req    = owner ? c_req  : h_req;
    own_lock   = owner ? c_lock : h_lock;
    locked     = lock_q && own_lock;
    grant      = 1'b0;
    grant_side = owner;
    if (locked) begin
      grant      = own_req;
      grant_side = owner;
    end else if (h_req && c_req) begin
      grant      = 1'b1;
      grant_side = ~owner;
    end else if (h_req || c_req) begin
      grant      = 1'b1;
      grant_side = c_req;
    end
    wd_fire = locked && !own_req && (wd_cnt_q == WD_LAST);

    case (state_q)
      S_IDLE:  if (grant) state_d = S_ISSUE;
      S_ISSUE: state_d = (RD_LATENCY > 1) ? S_WAIT : S_ACK;
      S_WAIT:  if (wait_cnt_q == WAIT_LAST) state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are pure decodes of registered state, so no input reaches an output combinationally.
  always_comb begin
    reg_req = (state_q == S_ISSUE);
    h_ack   = (state_q == S_ACK) && !owner;
    c_ack   = (state_q == S_ACK) && owner;
    busy    = (state_q != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      owner        <= 1'b1;
      lock_q       <= 1'b0;
      lock_abort   <= 1'b0;
      wd_cnt_q     <= '0;
      wait_cnt_q   <= '0;
      reg_dir      <= 1'b1;
      reg_size     <= '0;
      reg_addr     <= '0;
      reg_baseAddr <= '0;
      reg_wrByte   <= '0;
      h_rdByte     <= '0;
      c_rdByte     <= '0;
    end else begin
      // NOTE: non-blocking so every register updates from pre-edge values.
      lock_abort <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!locked || own_req || wd_fire) wd_cnt_q <= '0;
          else                               wd_cnt_q <= wd_cnt_q + 8'd1;
          if (!locked || wd_fire) lock_q <= 1'b0;
          if (wd_fire) lock_abort <= 1'b1;
          if (grant) begin
            owner        <= grant_side;
            reg_dir      <= grant_side ? c_dir      : h_dir;
            reg_size     <= grant_side ? c_size     : h_size;
            reg_addr     <= grant_side ? c_addr     : h_addr;
            reg_baseAddr <= grant_side ? c_baseAddr : h_baseAddr;
            reg_wrByte   <= grant_side ? c_wrByte   : h_wrByte;
          end
        end
        S_ISSUE: wait_cnt_q <= '0;
        S_WAIT:  wait_cnt_q <= wait_cnt_q + 4'd1;
        S_ACK:   lock_q <= own_lock;
        default: ;
      endcase
      // Read data is captured on the edge entering ACK so it is visible alongside the ack.
      if (state_d == S_ACK && reg_dir) begin
        if (owner) c_rdByte <= reg_rdByte;
        else       h_rdByte <= reg_rdByte;
      end
    end
  end

endmodule
